// File: rtl/mux_scan_sampler.sv
// Scan sequencer around a 32:1 mux: walks the select over a (possibly wrapping)
// channel range, samples the mux output after a settle delay and assembles a 32-bit word.
module mux_scan_sampler #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [4:0]  first_ch,
    input  logic [4:0]  last_ch,
    output logic [4:0]  sel,
    input  logic        y,
    output logic [31:0] data,
    output logic        valid,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SAMPLE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);
    // With no settle time a freshly loaded channel is sampled on the very next edge.
    localparam state_t ENTRY_STATE = (SETTLE == 0) ? S_SAMPLE : S_WAIT;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  sel_q, sel_d;
    logic [4:0]  last_q, last_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;

    function automatic logic [31:0] capture_bit(input logic [31:0] word,
                                                input logic [4:0]  idx,
                                                input logic        bit_v);
        logic [31:0] res;
        res      = word;
        res[idx] = bit_v;
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            sel_q   <= 5'd0;
            last_q  <= 5'd0;
            data_q  <= 32'h0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        data_d  = data_q;
        valid_d = 1'b0;
        busy_d  = busy_q;

        unique case (state_q)
            S_IDLE: begin
                // abort wins over a simultaneous start even while idle
                if (start && !abort) begin
                    last_d  = last_ch;
                    sel_d   = first_ch;
                    data_d  = 32'h0;
                    busy_d  = 1'b1;
                    cnt_d   = SETTLE_CNT;
                    state_d = ENTRY_STATE;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    data_d  = 32'h0;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        cnt_d   = 4'd0;
                        state_d = S_SAMPLE;
                    end
                end
            end
            S_SAMPLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    data_d  = 32'h0;
                    cnt_d   = 4'd0;
                end else begin
                    data_d = capture_bit(data_q, sel_q, y);
                    if (sel_q == last_q) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        valid_d = 1'b1;
                        cnt_d   = 4'd0;
                    end else begin
                        // 5-bit increment gives the 31 -> 0 wrap for free
                        sel_d   = sel_q + 5'd1;
                        cnt_d   = SETTLE_CNT;
                        state_d = ENTRY_STATE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign sel   = sel_q;
    assign data  = data_q;
    assign valid = valid_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Bench for mux_scan_sampler: three instances with SETTLE = 0, 1, 2 each see a modelled 32:1 mux.
module tb_mux_scan_sampler;

    logic        clk;
    logic        rst_n;
    logic [2:0]  start_r;
    logic [2:0]  abort_r;
    logic [4:0]  first_r [3];
    logic [4:0]  last_r  [3];
    logic [31:0] mux_in  [3];
    logic [4:0]  sel_w   [3];
    logic [2:0]  y_w;
    logic [31:0] data_w  [3];
    logic [2:0]  valid_w;
    logic [2:0]  busy_w;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int          idx;
        logic [4:0]  first;
        logic [4:0]  last;
        logic [31:0] mux;
        logic [31:0] exp_data;
        int          lat;
        int          poke;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        int          lat;
    } exp_t;

    vec_t vecs [10];
    exp_t sb [$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mux_scan_sampler #(.SETTLE(g)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start_r[g]),
            .abort    (abort_r[g]),
            .first_ch (first_r[g]),
            .last_ch  (last_r[g]),
            .sel      (sel_w[g]),
            .y        (y_w[g]),
            .data     (data_w[g]),
            .valid    (valid_w[g]),
            .busy     (busy_w[g])
        );
        assign y_w[g] = mux_in[g][sel_w[g]];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Starts a scan at the current negedge and follows it to its valid pulse.
    // Returns at the negedge where valid is seen, so a following call runs back-to-back.
    task automatic run_scan(input int idx, input logic [4:0] first, input logic [4:0] last,
                            input logic [31:0] mux, input logic [31:0] exp_data,
                            input int lat, input int poke);
        logic [4:0] seq [$];
        exp_t       e;
        int         m;
        int         n;
        bit         got;
        mux_in[idx]  = mux;
        first_r[idx] = first;
        last_r[idx]  = last;
        sb.push_back('{exp_data, lat});
        start_r[idx] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_r[idx] = 1'b0;
        check($sformatf("busy_at_accept[%0d]", idx), 32'(busy_w[idx]), 32'd1);
        check($sformatf("valid_low_at_accept[%0d]", idx), 32'(valid_w[idx]), 32'd0);
        check($sformatf("sel_first[%0d]", idx), 32'(sel_w[idx]), 32'(first));
        seq.push_back(sel_w[idx]);
        m   = 0;
        got = 0;
        while (!got && m < 300) begin
            if (valid_w[idx]) begin
                got = 1;
            end else begin
                if (m == poke && poke != 0) begin
                    start_r[idx] = 1'b1;
                    first_r[idx] = first + 5'd9;
                    last_r[idx]  = first + 5'd9;
                end else begin
                    start_r[idx] = 1'b0;
                end
                @(posedge clk);
                @(negedge clk);
                m++;
                if (sel_w[idx] != seq[$]) seq.push_back(sel_w[idx]);
            end
        end
        start_r[idx] = 1'b0;
        e = sb.pop_front();
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL scan_timeout[%0d]: no valid after %0d cycles, required at %0d", idx, m, e.lat);
        end else begin
            n = int'(5'(last - first)) + 1;
            check($sformatf("data[%0d]", idx), data_w[idx], e.data);
            check($sformatf("latency[%0d]", idx), 32'(m), 32'(e.lat));
            check($sformatf("busy_done[%0d]", idx), 32'(busy_w[idx]), 32'd0);
            check($sformatf("sel_hold_last[%0d]", idx), 32'(sel_w[idx]), 32'(last));
            check($sformatf("sel_seq_len[%0d]", idx), 32'(seq.size()), 32'(n));
            for (int i = 0; i < seq.size() && i < n; i++)
                check($sformatf("sel_seq[%0d][%0d]", idx, i), 32'(seq[i]), 32'(5'(first + 5'(i))));
        end
    endtask

    initial begin
        bit seen;
        rst_n   = 1'b0;
        start_r = '0;
        abort_r = '0;
        for (int i = 0; i < 3; i++) begin
            first_r[i] = '0;
            last_r[i]  = '0;
            mux_in[i]  = '0;
        end

        vecs[0] = '{1, 5'd0,  5'd31, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 64, 0};
        vecs[1] = '{1, 5'd7,  5'd7,  32'h0000_0080, 32'h0000_0080, 2,  0};
        vecs[2] = '{1, 5'd4,  5'd6,  32'hFFFF_FFFF, 32'h0000_0070, 6,  0};
        vecs[3] = '{2, 5'd30, 5'd1,  32'hFFFF_FFFF, 32'hC000_0003, 12, 0};
        vecs[4] = '{2, 5'd31, 5'd0,  32'hFFFF_FFFF, 32'h8000_0001, 6,  0};
        vecs[5] = '{2, 5'd0,  5'd3,  32'h0000_000F, 32'h0000_000F, 12, 3};
        vecs[6] = '{0, 5'd0,  5'd3,  32'h0000_000A, 32'h0000_000A, 4,  0};
        vecs[7] = '{0, 5'd31, 5'd30, 32'h1234_5678, 32'h1234_5678, 32, 0};
        vecs[8] = '{0, 5'd5,  5'd5,  32'hFFFF_FFFF, 32'h0000_0020, 1,  0};
        vecs[9] = '{0, 5'd16, 5'd19, 32'hDEAD_BEEF, 32'h000D_0000, 4,  0};

        #12;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_sel[%0d]", i), 32'(sel_w[i]), 32'd0);
            check($sformatf("rst_data[%0d]", i), data_w[i], 32'd0);
            check($sformatf("rst_valid[%0d]", i), 32'(valid_w[i]), 32'd0);
            check($sformatf("rst_busy[%0d]", i), 32'(busy_w[i]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 10; v++)
            run_scan(vecs[v].idx, vecs[v].first, vecs[v].last, vecs[v].mux,
                     vecs[v].exp_data, vecs[v].lat, vecs[v].poke);

        // valid is a single pulse, data holds; abort with start while idle does nothing
        @(posedge clk);
        @(negedge clk);
        check("valid_drop", 32'(valid_w[0]), 32'd0);
        check("data_hold", data_w[0], 32'h000D_0000);
        first_r[0] = 5'd0;
        last_r[0]  = 5'd0;
        start_r[0] = 1'b1;
        abort_r[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_r[0] = 1'b0;
        abort_r[0] = 1'b0;
        check("idle_abort_busy", 32'(busy_w[0]), 32'd0);
        check("idle_abort_data", data_w[0], 32'h000D_0000);
        check("idle_abort_sel", 32'(sel_w[0]), 32'd19);

        // mid-scan start ignored, then abort at channel 5
        mux_in[1]  = 32'hFFFF_FFFF;
        first_r[1] = 5'd0;
        last_r[1]  = 5'd31;
        start_r[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_r[1] = 1'b0;
        for (int c = 0; c < 50 && sel_w[1] != 5'd2; c++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("reach_ch2", 32'(sel_w[1]), 32'd2);
        first_r[1] = 5'd20;
        last_r[1]  = 5'd20;
        start_r[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_r[1] = 1'b0;
        check("ignored_start_sel", 32'(sel_w[1] != 5'd20), 32'd1);
        check("ignored_start_busy", 32'(busy_w[1]), 32'd1);
        for (int c = 0; c < 50 && sel_w[1] != 5'd5; c++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("reach_ch5", 32'(sel_w[1]), 32'd5);
        check("partial_data", data_w[1], 32'h0000_001F);
        abort_r[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort_r[1] = 1'b0;
        check("abort_busy", 32'(busy_w[1]), 32'd0);
        check("abort_data", data_w[1], 32'h0);
        seen = 0;
        check("abort_valid", 32'(valid_w[1]), 32'd0);
        for (int c = 0; c < 80; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid_w[1]) seen = 1;
        end
        check("abort_no_valid", 32'(seen), 32'd0);
        run_scan(1, 5'd0, 5'd3, 32'h0000_000A, 32'h0000_000A, 8, 0);

        // asynchronous reset mid-scan
        @(posedge clk);
        @(negedge clk);
        mux_in[1]  = 32'hA5A5_0F0F;
        first_r[1] = 5'd0;
        last_r[1]  = 5'd31;
        start_r[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_r[1] = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check("pre_rst_sel", 32'(sel_w[1]), 32'd5);
        check("pre_rst_data", data_w[1], 32'h0000_000F);
        rst_n = 1'b0;
        #1;
        check("async_rst_sel", 32'(sel_w[1]), 32'd0);
        check("async_rst_data", data_w[1], 32'h0);
        check("async_rst_valid", 32'(valid_w[1]), 32'd0);
        check("async_rst_busy", 32'(busy_w[1]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_scan(1, 5'd0, 5'd3, 32'h0000_000A, 32'h0000_000A, 8, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux_scan_sampler.md
# mux_scan_sampler

Sequencer that sits directly upstream and downstream of the 32-to-1 multiplexer: it drives the mux select and samples the mux output. On a start request it walks the select through a programmable channel range, which may wrap around. After a configurable settle time on each channel it captures the mux output into the matching bit of a 32-bit result word. When the last channel has been captured it presents the assembled word with a one-cycle valid pulse, giving the design a serial-scan path from a 32-input bus to a parallel register.

## Interface
- SETTLE, default 1: idle cycles between loading a select value and sampling `y`. Legal range 0..15.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  scan request; sampled in IDLE only.
- abort  input  1  synchronous scan cancel.
- first_ch  input  5  first channel of scan; latched on start acceptance.
- last_ch  input  5  last channel of scan; latched on start acceptance.
- sel  output  5  mux select, registered.
- y  input  1  mux output being sampled.
- data  output  32  captured word; bit i = `y` sampled with sel=i.
- valid  output  1  one-cycle pulse; `data` is complete.
- busy  output  1  scan in progress.

## Operation
- States:
  - IDLE: waits for start.
  - WAIT: counts settle cycles.
  - SAMPLE: captures `y`.
  - No separate DONE state; completion is taken from SAMPLE straight back to IDLE.
- IDLE with start=1 at an edge:
  - Latch first_ch and last_ch.
  - Load sel=first_ch, clear data to 0, set busy=1, load the settle counter with SETTLE.
  - Enter WAIT, or enter SAMPLE directly when SETTLE=0.
- WAIT: decrement the counter each edge; when it reaches 0, enter SAMPLE.
- SAMPLE edge:
  - Write data[sel] <= y.
  - If sel == latched last: busy <= 0, valid <= 1, go to IDLE, and sel holds its value.
  - Otherwise: sel <= sel+1 mod 32 (31 wraps to 0), reload the counter, and re-enter WAIT (or stay in SAMPLE when SETTLE=0).
- Channel count N = ((last − first) mod 32) + 1, range 1..32.
  - first == last scans exactly one channel.
  - last == first−1 (mod 32) scans all 32 channels.
- Bits outside the scanned range read 0.
- start while busy: ignored; the latched range is unaffected.
- abort=1 while busy:
  - At the next edge go to IDLE with busy=0 and data cleared to 0.
  - valid is not asserted.
  - abort has priority over the sample/complete action in the same cycle.
  - abort in IDLE has no effect; abort and start together in IDLE means start is ignored.
- valid deasserts after one cycle.
- data holds its value after valid until the next accepted start or an abort.

## Timing
- Reset values: sel=0, data=32'h0, valid=0, busy=0, state IDLE, counter 0.
- rst_n low at any point, including mid-scan, forces these values immediately (asynchronous). The first start is accepted at the first rising edge after rst_n is released.
- sel changes only at a start-accept edge or a SAMPLE edge.
- `y` is sampled SETTLE+1 edges after the edge that loaded the current sel.
- Each channel costs SETTLE+1 cycles.
- With start accepted at edge k:
  - valid=1 and busy=0 are visible from edge k + N·(SETTLE+1).
  - valid drops at the following edge.
- A new start is accepted at the same edge at which valid falls, giving back-to-back scans.
- `y` is treated as combinational from sel. No synchronizer is placed on `y`.

## Test plan
- Full scan: first=0, last=31, SETTLE=1, mux inputs I=32'hA5A5_0F0F.
  - valid pulses at edge k+64 with data=32'hA5A5_0F0F.
  - sel sequence is 0..31; busy is high for 64 cycles.
- Single channel: first=last=7, SETTLE=1, I=32'h0000_0080.
  - data=32'h0000_0080, valid at k+2, sel stays 7 afterwards.
- Wrap scan: first=30, last=1, SETTLE=2, I=32'hFFFF_FFFF.
  - sel sequence is 30, 31, 0, 1.
  - data=32'hC000_0003, valid at k+12.
- SETTLE=0, first=0, last=3, I=32'h0000_000A.
  - One channel per cycle; data=32'h0000_000A, valid at k+4.
- start pulsed mid-scan, then abort at channel 5 of a 0..31 scan.
  - The mid-scan start is ignored.
  - After abort: busy=0 and data=0 at the next edge; valid never rises; a following start scans normally.
- rst_n pulled low mid-scan.
  - sel, data, valid and busy read 0 before the next clock edge.
  - After release, a fresh scan of 0..3 completes with correct data.
